// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the memory arbiter
package mem_pkg;

    localparam int ROM_RAM_SEL_BIT = 10;
    localparam int RAM_IDX_HI      = 9;
    localparam int RAM_IDX_LO      = 2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - data-first priority select with fetch starvation counter
module mem_arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic accept_en,
    input  logic if_req_valid,
    input  logic d_req_valid,
    output logic grant_if,
    output logic grant_d
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    // Fetch overrides data only once it has watched LIMIT data grants go by.
    assign starved  = (starve_cnt == LIMIT) && if_req_valid;
    assign grant_d  = accept_en && d_req_valid && !starved;
    assign grant_if = accept_en && if_req_valid && (!d_req_valid || starved);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req_valid || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter sharing ROM/RAM between fetch and load/store
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_resp_valid,
    output logic [DATA_WIDTH-1:0] if_resp_data,
    output logic                  if_resp_err,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_write,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  d_resp_err,
    output logic                  mem_en,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t state, state_nxt;
    owner_t owner;
    logic   write_q, err_q;

    logic                  accept_en, accept;
    logic                  grant_if, grant_d;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write, sel_err;
    logic                  in_resp;
    logic [DATA_WIDTH-1:0] resp_word;

    assign accept_en = (state == ST_IDLE) || (state == ST_RESP);

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk          (clk),
        .reset        (reset),
        .accept_en    (accept_en),
        .if_req_valid (if_req_valid),
        .d_req_valid  (d_req_valid),
        .grant_if     (grant_if),
        .grant_d      (grant_d)
    );

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;
    assign accept       = grant_if || grant_d;

    assign sel_addr  = grant_d ? d_addr : if_addr;
    assign sel_write = grant_d && d_write;
    assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_write && !sel_addr[ROM_RAM_SEL_BIT]);

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = accept ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = accept ? ST_ISSUE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // mem_addr/mem_wdata only move for legal accesses so the bus stays quiet on rejects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner   <= grant_d ? OWN_D : OWN_IF;
                write_q <= sel_write;
                err_q   <= sel_err;
                if (!sel_err) begin
                    mem_addr <= sel_addr;
                end
                if (sel_write && !sel_err) begin
                    mem_wdata <= d_wdata;
                end
            end
        end
    end

    assign mem_en    = (state == ST_ISSUE) && !err_q;
    assign mem_write = mem_en && write_q;

    assign in_resp   = (state == ST_RESP);
    assign resp_word = (err_q || write_q) ? '0 : mem_rdata;

    assign if_resp_valid = in_resp && (owner == OWN_IF);
    assign if_resp_data  = if_resp_valid ? resp_word : '0;
    assign if_resp_err   = if_resp_valid && err_q;

    assign d_resp_valid  = in_resp && (owner == OWN_D);
    assign d_resp_data   = d_resp_valid ? resp_word : '0;
    assign d_resp_err    = d_resp_valid && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_addr;
    logic        if_resp_valid, if_resp_err;
    logic [31:0] if_resp_data;
    logic        d_req_valid, d_req_ready, d_write;
    logic [31:0] d_addr, d_wdata;
    logic        d_resp_valid, d_resp_err;
    logic [31:0] d_resp_data;
    logic        mem_en, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rv;
    int n;
    byte got [10];
    string exp_seq = "DDDDIDDDDI";
    logic [31:0] ram [256];

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .if_resp_err   (if_resp_err),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_addr        (d_addr),
        .d_write       (d_write),
        .d_wdata       (d_wdata),
        .d_resp_valid  (d_resp_valid),
        .d_resp_data   (d_resp_data),
        .d_resp_err    (d_resp_err),
        .mem_en        (mem_en),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // Memory stub: ROM word is 0xA500_0000 | address, RAM is 256 words, one-cycle read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_write) begin
                if (mem_addr[10]) ram[mem_addr[9:2]] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                mem_rdata <= mem_addr[10] ? ram[mem_addr[9:2]] : (32'hA500_0000 | mem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        if_req_valid = 1'b0; if_addr = '0;
        d_req_valid = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        #1;
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp", {30'd0, if_resp_valid, d_resp_valid}, 32'd0);
        chk("rst_ready", {30'd0, if_req_ready, d_req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single fetch from ROM
        if_req_valid = 1'b1; if_addr = 32'h40;
        #1 chk("f1_ready", {30'd0, if_req_ready, d_req_ready}, 32'd2);
        step();
        if_req_valid = 1'b0;
        chk("f1_mem_en", {31'd0, mem_en}, 32'd1);
        chk("f1_mem_write", {31'd0, mem_write}, 32'd0);
        chk("f1_mem_addr", mem_addr, 32'h40);
        step();
        chk("f1_resp_valid", {30'd0, if_resp_valid, d_resp_valid}, 32'd2);
        chk("f1_resp_data", if_resp_data, 32'hA500_0040);
        chk("f1_resp_err", {31'd0, if_resp_err}, 32'd0);
        step();
        chk("f1_resp_done", {31'd0, if_resp_valid}, 32'd0);
        chk("f1_addr_hold", mem_addr, 32'h40);

        // Store to RAM then back-to-back load from the same word
        d_req_valid = 1'b1; d_write = 1'b1; d_addr = 32'h404; d_wdata = 32'hDEAD_BEEF;
        #1 chk("st_ready", {31'd0, d_req_ready}, 32'd1);
        step();
        d_req_valid = 1'b0;
        chk("st_mem_en", {30'd0, mem_en, mem_write}, 32'd3);
        chk("st_mem_addr", mem_addr, 32'h404);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        chk("st_resp_valid", {31'd0, d_resp_valid}, 32'd1);
        chk("st_resp_data", d_resp_data, 32'd0);
        chk("st_resp_err", {31'd0, d_resp_err}, 32'd0);
        d_req_valid = 1'b1; d_write = 1'b0; d_addr = 32'h404;
        #1 chk("ld_ready_in_resp", {31'd0, d_req_ready}, 32'd1);
        step();
        d_req_valid = 1'b0;
        chk("ld_mem_en", {30'd0, mem_en, mem_write}, 32'd2);
        step();
        chk("ld_resp_valid", {30'd0, if_resp_valid, d_resp_valid}, 32'd1);
        chk("ld_resp_data", d_resp_data, 32'hDEAD_BEEF);
        chk("ld_wr_cnt", wr_cnt, 32'd1);
        step();

        // Store into ROM is rejected
        d_req_valid = 1'b1; d_write = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234_5678;
        #1;
        step();
        d_req_valid = 1'b0; d_write = 1'b0;
        chk("rom_st_mem_en", {30'd0, mem_en, mem_write}, 32'd0);
        step();
        chk("rom_st_resp", {30'd0, d_resp_valid, d_resp_err}, 32'd3);
        chk("rom_st_data", d_resp_data, 32'd0);
        step();
        chk("rom_st_wr_cnt", wr_cnt, 32'd1);
        chk("rom_st_resp_done", {31'd0, d_resp_valid}, 32'd0);

        // Misaligned fetch is rejected
        if_req_valid = 1'b1; if_addr = 32'h2;
        #1;
        step();
        if_req_valid = 1'b0;
        chk("mis_mem_en", {31'd0, mem_en}, 32'd0);
        step();
        chk("mis_resp", {30'd0, if_resp_valid, if_resp_err}, 32'd3);
        chk("mis_data", if_resp_data, 32'd0);
        step();

        // Both requesters continuously valid: D,D,D,D,IF repeating
        if_req_valid = 1'b1; if_addr = 32'h100;
        d_req_valid = 1'b1; d_write = 1'b0; d_addr = 32'h400;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            #1;
            chk("one_ready", {31'd0, d_req_ready && if_req_ready}, 32'd0);
            if (d_req_ready) begin
                got[n] = "D"; n++;
            end else if (if_req_ready) begin
                got[n] = "I"; n++;
            end
            step();
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        chk("starve_grants", n, 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("starve_grant%0d", i), {24'd0, got[i]}, {24'd0, exp_seq[i]});
        end
        repeat (3) step();

        // Reset during ISSUE drops the load; the next one completes normally
        d_req_valid = 1'b1; d_write = 1'b0; d_addr = 32'h404;
        #1;
        step();
        d_req_valid = 1'b0;
        chk("rst_issue_mem_en", {31'd0, mem_en}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
        #1 reset = 1'b0;
        rv = 0;
        repeat (3) begin
            step();
            if (d_resp_valid) rv++;
        end
        chk("rst_no_resp", rv, 32'd0);
        d_req_valid = 1'b1; d_addr = 32'h404;
        #1 chk("post_rst_ready", {31'd0, d_req_ready}, 32'd1);
        step();
        d_req_valid = 1'b0;
        chk("post_rst_mem_en", {31'd0, mem_en}, 32'd1);
        step();
        chk("post_rst_resp", {30'd0, d_resp_valid, d_resp_err}, 32'd2);
        chk("post_rst_data", d_resp_data, 32'hDEAD_BEEF);
        step();
        chk("post_rst_done", {31'd0, d_resp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the unified instruction/data memory (ROM below address bit 10, 256-word RAM above it) between the core's instruction-fetch port and its load/store port. It owns the memory's enable, address, write strobe and write data, allows one outstanding access at a time, and returns each response to the requester that issued it. Data accesses have priority, and a starvation limit guarantees forward progress for fetch. Illegal accesses (ROM writes, misaligned addresses) are rejected without touching memory.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (≥1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- if_req_valid / if_req_ready  in / out  1  fetch request handshake
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_resp_valid  out  1  one-cycle fetch response strobe
- if_resp_data  out  DATA_WIDTH  fetched word
- if_resp_err  out  1  fetch rejected (misaligned)
- d_req_valid / d_req_ready  in / out  1  data request handshake
- d_addr  in  ADDR_WIDTH  data byte address
- d_write  in  1  1 = store, 0 = load
- d_wdata  in  DATA_WIDTH  store data
- d_resp_valid  out  1  one-cycle data response strobe
- d_resp_data  out  DATA_WIDTH  load word (0 for stores/errors)
- d_resp_err  out  1  access rejected
- mem_en  out  1  memory access strobe
- mem_write  out  1  memory write strobe (RAM only)
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_en

## Operation
- FSM: IDLE, ISSUE, RESP. IDLE/RESP may accept; ISSUE never accepts.
- Accept (valid & ready) → ISSUE next cycle; ISSUE → RESP; RESP → ISSUE if a new accept occurred, else IDLE.
- Ready asserted only to the arbitration winner, only in IDLE/RESP; at most one ready high per cycle.
- Requester holds valid and payload stable until accepted; arbiter latches payload and owner on accept.
- Priority: data wins unless starve_cnt == STARVE_LIMIT and if_req_valid, then fetch wins.
- starve_cnt: +1 on data grant while if_req_valid; cleared on fetch grant or when if_req_valid is low; saturates at STARVE_LIMIT.
- Error checks at accept: addr[1:0] ≠ 0 → err; d_write with addr[10] = 0 → err. Errored access: mem_en stays 0 during ISSUE; RESP gives err = 1, data = 0.
- Legal load/fetch: ISSUE drives mem_en = 1, mem_write = 0, latched addr; RESP passes mem_rdata to owner's resp_data.
- Legal store (addr[10] = 1): ISSUE drives mem_en = 1, mem_write = 1, mem_wdata; RESP gives data = 0, err = 0.
- Outside ISSUE: mem_en = 0, mem_write = 0; mem_addr/mem_wdata hold last value.

## Timing
- Reset: state IDLE, starve_cnt 0, every output 0.
- Accept in cycle N → mem_en in N+1 → resp_valid in N+2 for exactly one cycle, on the owner's port only.
- Back-to-back throughput: one access per 2 cycles (accept in RESP).
- Both requesters valid in same cycle: data granted unless starvation rule fires.
- Reset asserted mid-transaction: access is dropped and no response is issued; a store already strobed in ISSUE may have committed.
- No combinational path from mem_rdata to any ready; ready depends on state and request valids.

## Structure
- Shared package mem_pkg: ROM_RAM_SEL_BIT = 10, RAM word index range [9:2], FSM state typedef, owner enum (OWN_IF, OWN_D).
- One sub-module, mem_arb_grant: priority select plus starve_cnt register; outputs grant_if/grant_d.

## Test plan
- Single fetch at 0x0000_0040 accepted in cycle 1 → mem_en/mem_addr = 0x40 in cycle 2; if_resp_valid in cycle 3 with ROM word, err = 0.
- Store 0xDEAD_BEEF to 0x0000_0404, then load from 0x404 → mem_write = 1 once; load returns 0xDEAD_BEEF on d_resp_data.
- Store to 0x0000_0010 (ROM) → mem_en never high; d_resp_err = 1, d_resp_data = 0 two cycles after accept.
- Fetch at 0x0000_0002 → if_resp_err = 1, no mem_en.
- Both valid continuously with STARVE_LIMIT = 4 → grant sequence D,D,D,D,IF repeating; fetch never waits more than 4 grants.
- Reset pulse during ISSUE of a load → no d_resp_valid after release; next request completes normally with 2-cycle latency.
